// File: rtl/pov_update_arbiter.sv
// pov_update_arbiter
//   Schedules updates to the live POV vector registers. Updates happen only
//   inside a vertical-blanking window, so the tracer never sees the vectors
//   change mid-frame. Two requesters compete for each window:
//     - SPI host frames  : served by a one-cycle pulse to pov load_if_ready
//     - local motion unit: served by a grant held until done or abort
//   Only one update is allowed per window. SPI wins by default, but a pending,
//   eligible motion request takes the window after MAX_SPI_STREAK consecutive
//   SPI loads.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   i_vblank_start in   1-cycle pulse at the start of vertical blanking
//   i_vblank       in   level, high for the whole blanking interval
//   i_spi_new      in   1-cycle pulse, new SPI frame buffered in pov
//   i_mot_req      in   level, motion unit has a step pending
//   i_mot_done     in   1-cycle pulse, motion unit finished writing
//   i_freeze       in   level, windows are ignored while high
//   o_load_spi     out  1-cycle load pulse to pov
//   o_mot_grant    out  motion write grant
//   o_busy         out  high whenever the FSM is not idle
//   o_last_src     out  00 none, 01 SPI, 10 motion, 11 motion aborted
//   o_aborts       out  saturating count of aborted motion grants
//   o_missed       out  saturating count of windows closed with work pending
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for an unfrozen vblank start
// ARB      | one-cycle arbitration between SPI and motion
// LOAD_SPI | one-cycle load pulse to pov
// MOTION   | grant held, waiting for done, vblank end or timeout
// WAIT_END | window already used, waiting for vblank to fall

module pov_update_arbiter #(
    parameter int MAX_SPI_STREAK = 4,
    parameter int MOTION_DIV     = 1,
    parameter int TIMEOUT        = 1023,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_vblank_start,
    input  logic             i_vblank,
    input  logic             i_spi_new,
    input  logic             i_mot_req,
    input  logic             i_mot_done,
    input  logic             i_freeze,
    output logic             o_load_spi,
    output logic             o_mot_grant,
    output logic             o_busy,
    output logic [1:0]       o_last_src,
    output logic [CNT_W-1:0] o_aborts,
    output logic [CNT_W-1:0] o_missed
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(MAX_SPI_STREAK + 1);
    localparam int DIV_W = (MOTION_DIV > 1) ? $clog2(MOTION_DIV) : 1;

    localparam logic [1:0] SRC_SPI   = 2'b01;
    localparam logic [1:0] SRC_MOT   = 2'b10;
    localparam logic [1:0] SRC_ABORT = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        LOAD_SPI = 3'd2,
        MOTION   = 3'd3,
        WAIT_END = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [STK_W-1:0] streak_q, streak_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mot_due_q, mot_due_d;
    logic             spi_pend_q, spi_pend_d;
    logic             load_spi_q, load_spi_d;
    logic             mot_grant_q, mot_grant_d;
    logic [1:0]       last_src_q, last_src_d;
    logic [CNT_W-1:0] aborts_q, aborts_d;
    logic [CNT_W-1:0] missed_q, missed_d;

    logic mot_ok;
    logic mot_abort;
    logic div_wrap;

    assign mot_ok    = i_mot_req & mot_due_q;
    // Done wins over a coincident abort condition.
    assign mot_abort = !i_mot_done && (!i_vblank || (timer_q == TMR_W'(TIMEOUT)));
    assign div_wrap  = (div_cnt_q == DIV_W'(MOTION_DIV - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            streak_q    <= '0;
            div_cnt_q   <= '0;
            mot_due_q   <= (MOTION_DIV == 1);
            spi_pend_q  <= 1'b0;
            load_spi_q  <= 1'b0;
            mot_grant_q <= 1'b0;
            last_src_q  <= 2'b00;
            aborts_q    <= '0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            streak_q    <= streak_d;
            div_cnt_q   <= div_cnt_d;
            mot_due_q   <= mot_due_d;
            spi_pend_q  <= spi_pend_d;
            load_spi_q  <= load_spi_d;
            mot_grant_q <= mot_grant_d;
            last_src_q  <= last_src_d;
            aborts_q    <= aborts_d;
            missed_q    <= missed_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_vblank_start && !i_freeze) state_d = ARB;
            end
            ARB: begin
                if (spi_pend_q && !(mot_ok && (streak_q >= STK_W'(MAX_SPI_STREAK))))
                    state_d = LOAD_SPI;
                else if (mot_ok)
                    state_d = MOTION;
                else
                    state_d = WAIT_END;
            end
            LOAD_SPI: state_d = WAIT_END;
            MOTION: begin
                if (i_mot_done || mot_abort) state_d = WAIT_END;
            end
            WAIT_END: begin
                if (!i_vblank) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and bookkeeping logic; everything except o_busy is registered.
    always_comb begin
        timer_d     = '0;
        streak_d    = streak_q;
        div_cnt_d   = div_cnt_q;
        mot_due_d   = mot_due_q;
        last_src_d  = last_src_q;
        aborts_d    = aborts_q;
        missed_d    = missed_q;
        load_spi_d  = (state_d == LOAD_SPI);
        mot_grant_d = (state_d == MOTION);

        // Held pending if a new frame lands on the same cycle as the load.
        spi_pend_d  = i_spi_new | (spi_pend_q & (state_q != LOAD_SPI));

        // The divider sees every vblank start, even ignored ones.
        if (i_mot_done) mot_due_d = 1'b0;
        if (i_vblank_start) begin
            if (div_wrap) begin
                div_cnt_d = '0;
                mot_due_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        if (state_d == LOAD_SPI) last_src_d = SRC_SPI;

        if (state_q == LOAD_SPI && streak_q < STK_W'(MAX_SPI_STREAK))
            streak_d = streak_q + STK_W'(1);

        if (state_q == MOTION) begin
            timer_d = timer_q + TMR_W'(1);
            if (i_mot_done) begin
                streak_d   = '0;
                last_src_d = SRC_MOT;
            end else if (mot_abort) begin
                last_src_d = SRC_ABORT;
                if (aborts_q != '1) aborts_d = aborts_q + CNT_W'(1);
            end
        end

        if (state_q == WAIT_END && !i_vblank && (spi_pend_q || mot_ok)) begin
            if (missed_q != '1) missed_d = missed_q + CNT_W'(1);
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_load_spi  = load_spi_q;
    assign o_mot_grant = mot_grant_q;
    assign o_last_src  = last_src_q;
    assign o_aborts    = aborts_q;
    assign o_missed    = missed_q;

endmodule

// File: tb/tb_pov_update_arbiter.sv
module tb_pov_update_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int DIV        = 2;
    localparam int TO         = 15;
    localparam int CW         = 3;
    localparam int SAT        = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_vblank_start = 1'b0;
    logic          i_vblank = 1'b0;
    logic          i_spi_new = 1'b0;
    logic          i_mot_req = 1'b0;
    logic          i_mot_done = 1'b0;
    logic          i_freeze = 1'b0;
    logic          o_load_spi;
    logic          o_mot_grant;
    logic          o_busy;
    logic [1:0]    o_last_src;
    logic [CW-1:0] o_aborts;
    logic [CW-1:0] o_missed;

    pov_update_arbiter #(
        .MAX_SPI_STREAK (MAX_STREAK),
        .MOTION_DIV     (DIV),
        .TIMEOUT        (TO),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_vblank_start (i_vblank_start),
        .i_vblank       (i_vblank),
        .i_spi_new      (i_spi_new),
        .i_mot_req      (i_mot_req),
        .i_mot_done     (i_mot_done),
        .i_freeze       (i_freeze),
        .o_load_spi     (o_load_spi),
        .o_mot_grant    (o_mot_grant),
        .o_busy         (o_busy),
        .o_last_src     (o_last_src),
        .o_aborts       (o_aborts),
        .o_missed       (o_missed)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Window-level reference model
    bit m_spi_pend;
    int m_streak;
    int m_div;
    bit m_due;
    int m_aborts;
    int m_missed;
    int m_last;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_spi_pend = 0;
        m_streak   = 0;
        m_div      = 0;
        m_due      = (DIV == 1);
        m_aborts   = 0;
        m_missed   = 0;
        m_last     = 0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_load"},   int'(o_load_spi),  0);
        chk({pfx, "_grant"},  int'(o_mot_grant), 0);
        chk({pfx, "_busy"},   int'(o_busy),      0);
        chk({pfx, "_last"},   int'(o_last_src),  m_last);
        chk({pfx, "_aborts"}, int'(o_aborts),    m_aborts);
        chk({pfx, "_missed"}, int'(o_missed),    m_missed);
    endtask

    task automatic gap(input int g, input bit spi);
        for (int c = 0; c < g; c++) begin
            @(posedge clk); #1;
            i_vblank_start = 1'b0;
            i_vblank       = 1'b0;
            i_mot_done     = 1'b0;
            i_freeze       = 1'b0;
            i_spi_new      = (spi && c == 0);
        end
        if (spi) m_spi_pend = 1;
        @(posedge clk); #1;
        i_spi_new = 1'b0;
    endtask

    // One blanking window of len cycles; motion unit pulses done dly cycles
    // after its grant rises if the grant is still held then.
    task automatic run_window(input int len, input int dly, input bit req,
                              input bit frz, input bit spi_at_load);
        int  dec;
        bit  mot_ok;
        int  lim;
        int  end_k;
        bit  done_ok;
        int  ncyc;
        int  nload, ngrant, lc, gc;

        m_div = (m_div + 1) % DIV;
        if (m_div == 0) m_due = 1;

        dec = 0;
        end_k = 0;
        done_ok = 0;
        if (!frz) begin
            mot_ok = req && m_due;
            if (m_spi_pend && !(mot_ok && m_streak >= MAX_STREAK)) dec = 1;
            else if (mot_ok) dec = 2;
            else dec = 3;
        end
        if (dec == 2) begin
            lim = (len - 2 < TO) ? len - 2 : TO;
            if (dly <= lim) begin
                end_k = dly;
                done_ok = 1;
            end else begin
                end_k = lim;
            end
        end

        ncyc = ((len > 3 + end_k) ? len : 3 + end_k) + 3;
        nload = 0; ngrant = 0; lc = -1; gc = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            i_vblank_start = (c == 0);
            i_vblank       = (c < len);
            i_freeze       = frz;
            i_mot_req      = req;
            i_spi_new      = (spi_at_load && dec == 1 && c == 2);
            i_mot_done     = (done_ok && c == 2 + dly);
            @(negedge clk);
            if (o_load_spi) begin
                nload++;
                if (lc < 0) lc = c;
            end
            if (o_mot_grant) begin
                ngrant++;
                if (gc < 0) gc = c;
            end
        end
        @(posedge clk); #1;
        i_mot_done = 1'b0;
        i_spi_new  = 1'b0;
        i_freeze   = 1'b0;

        if (dec == 1) begin
            m_spi_pend = spi_at_load;
            if (m_streak < MAX_STREAK) m_streak++;
            m_last = 1;
        end else if (dec == 2) begin
            if (done_ok) begin
                m_streak = 0;
                m_last = 2;
                m_due = 0;
            end else begin
                if (m_aborts < SAT) m_aborts++;
                m_last = 3;
            end
        end
        if (!frz && (m_spi_pend || (req && m_due)))
            if (m_missed < SAT) m_missed++;

        chk("load_count", nload, (dec == 1) ? 1 : 0);
        if (dec == 1) chk("load_latency", lc, 2);
        chk("grant_cycles", ngrant, (dec == 2) ? end_k + 1 : 0);
        if (dec == 2) chk("grant_latency", gc, 2);
        @(negedge clk);
        check_idle_outputs("win");
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // SPI every window with a standing motion request: streak forces motion in.
        for (int w = 0; w < 12; w++) begin
            gap(2, 1'b1);
            run_window(10, 2, 1'b1, 1'b0, 1'b0);
        end

        // Motion unit never answers inside long windows: timeout aborts.
        for (int w = 0; w < 4; w++) begin
            gap(2, 1'b0);
            run_window(24, 40, 1'b1, 1'b0, 1'b0);
        end

        // Freeze: windows ignored entirely.
        gap(2, 1'b1);
        run_window(8, 1, 1'b1, 1'b1, 1'b0);
        run_window(8, 1, 1'b1, 1'b1, 1'b0);

        for (int w = 0; w < 70; w++) begin
            gap($urandom_range(1, 4), ($urandom % 2) == 0);
            run_window($urandom_range(2, 24), $urandom_range(0, 20),
                       ($urandom % 4) != 0, ($urandom % 8) == 0,
                       ($urandom % 6) == 0);
        end

        // Async reset while a grant is held.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        gap(2, 1'b0);
        run_window(4, 0, 1'b0, 1'b0, 1'b0);
        gap(2, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            i_vblank_start = (c == 0);
            i_vblank       = 1'b1;
            i_mot_req      = 1'b1;
        end
        @(negedge clk);
        chk("grant_before_reset", int'(o_mot_grant), 1);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("grant_async_reset", int'(o_mot_grant), 0);
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        i_vblank  = 1'b0;
        i_mot_req = 1'b0;
        reset     = 1'b0;

        // New SPI frame on the load cycle keeps the frame pending.
        gap(2, 1'b1);
        run_window(6, 0, 1'b0, 1'b0, 1'b1);
        gap(2, 1'b0);
        run_window(6, 0, 1'b0, 1'b0, 1'b0);
        gap(2, 1'b0);
        run_window(6, 0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
